// File: rtl/dma_pkg.sv
// Shared widths and FSM state encoding for the DMA read engine.
package dma_pkg;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;
endpackage

// File: rtl/dma_outstanding_ctr.sv
// Up/down counter of memory reads in flight. It holds at its bounds and
// flags when the value after this edge will be at the limit.
module dma_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full_nxt
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Next value: a simultaneous inc and dec cancel; the counter holds at 0 and MAX.
  always_comb begin
    count_nxt = count;
    if (inc && !dec && count != MAX_C)
      count_nxt = count + CNT_W'(1);
    else if (dec && !inc && count != '0)
      count_nxt = count - CNT_W'(1);
  end

  // The look-ahead flag lets the registered read request honour the limit next cycle.
  assign full_nxt = (count_nxt >= MAX_C);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end
endmodule

// File: rtl/dma_read_engine.sv
// Responder for layer DMA weight fetches. It accepts one request, issues
// word reads to memory with a bounded number in flight, and streams the
// returned words back to the requester. The last word carries eop.
module dma_read_engine #(
  parameter int ADDR_W          = dma_pkg::ADDR_W,
  parameter int DATA_W          = dma_pkg::DATA_W,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic              dma_engineer_ack,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              busy,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_dout_en,
  input  logic [DATA_W-1:0] mem_rd_dout
);
  import dma_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] rem_issue;
  logic [ADDR_W-1:0] rem_ret;
  logic [ADDR_W-1:0] rem_issue_nxt;
  logic              hs;
  logic              ret;
  logic              full_nxt;

  // A return is accepted only while a transfer is live; strays in IDLE are dropped.
  assign hs            = mem_rd_req && mem_rd_gnt;
  assign ret           = mem_rd_dout_en && (state != IDLE) && (rem_ret != '0);
  assign rem_issue_nxt = hs ? rem_issue - ADDR_W'(1) : rem_issue;

  dma_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_outstanding (
    .clk     (clk),
    .rst     (rst),
    .inc     (hs),
    .dec     (ret),
    .full_nxt(full_nxt)
  );

  // Control FSM plus return path. All outputs are registered here.
  // mem_rd_addr is the running read address, so it holds while a grant is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      rem_issue             <= '0;
      rem_ret               <= '0;
      dma_engineer_ack      <= 1'b0;
      dma_engineer_dout     <= '0;
      dma_engineer_dout_en  <= 1'b0;
      dma_engineer_dout_eop <= 1'b0;
      busy                  <= 1'b0;
      mem_rd_req            <= 1'b0;
      mem_rd_addr           <= '0;
    end else begin
      dma_engineer_ack      <= 1'b0;
      dma_engineer_dout_en  <= 1'b0;
      dma_engineer_dout_eop <= 1'b0;

      if (ret) begin
        dma_engineer_dout_en  <= 1'b1;
        dma_engineer_dout     <= mem_rd_dout;
        dma_engineer_dout_eop <= (rem_ret == ADDR_W'(1));
        rem_ret               <= rem_ret - ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          // The !ack term stops a req still high during the ack cycle from being accepted twice.
          if (dma_engineer_req && !dma_engineer_ack) begin
            dma_engineer_ack <= 1'b1;
            mem_rd_addr      <= dma_engineer_start_addr;
            rem_issue        <= dma_engineer_length;
            rem_ret          <= dma_engineer_length;
            if (dma_engineer_length != '0) begin
              state      <= ISSUE;
              busy       <= 1'b1;
              mem_rd_req <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
            rem_issue   <= rem_issue_nxt;
          end
          mem_rd_req <= (rem_issue_nxt != '0) && !full_nxt;
          if (hs && rem_issue == ADDR_W'(1))
            state <= DRAIN;
        end
        DRAIN: begin
          if (dma_engineer_dout_eop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dma_read_engine.md
Name: dma_read_engine

Overview:
- Responder end of the layer DMA request interface (req/ack, start_addr/length, dout/dout_en/dout_eop) that every conv/fc layer drives to fetch weights.
- Accepts one request at a time and issues word reads to the external memory read port.
- Streams the returned 512-bit words back to the requesting layer, marking the last beat with eop.
- Sits between the layer arbiter and the memory controller read channel.

Parameters:
- ADDR_W, 27, word address and length width (512-bit words).
- DATA_W, 512, beat width.
- MAX_OUTSTANDING, 8, maximum memory reads issued but not yet returned (2..64).
- CNT_W, 7, outstanding counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dma_engineer_req  in  1  request; held high with start_addr/length stable until ack
- dma_engineer_start_addr  in  ADDR_W  first word address
- dma_engineer_length  in  ADDR_W  number of words
- dma_engineer_ack  out  1  one-cycle accept pulse
- dma_engineer_dout  out  DATA_W  returned data beat
- dma_engineer_dout_en  out  1  beat valid
- dma_engineer_dout_eop  out  1  last beat of the transfer, coincident with dout_en
- busy  out  1  high from ack until the eop beat (inclusive)
- mem_rd_req  out  1  memory read request
- mem_rd_addr  out  ADDR_W  memory read word address
- mem_rd_gnt  in  1  memory accepts the request this cycle
- mem_rd_dout_en  in  1  memory returns one word, in order
- mem_rd_dout  in  DATA_W  returned word

Behaviour:
- Reset (rst high at a clock edge):
  - All outputs go to 0: ack, dout_en, dout_eop, busy, mem_rd_req, mem_rd_addr, dout.
  - State goes to IDLE; all counters are cleared.
  - Reset mid-transfer aborts the transfer with no eop.
  - Any mem_rd_dout_en arriving while IDLE is dropped; dout_en stays 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If req=1, assert ack for exactly one cycle.
  - Latch addr <= start_addr, remaining_issue <= length, remaining_ret <= length.
  - If length=0, stay IDLE: no mem reads, no beats, no eop, busy stays 0.
  - Otherwise go to ISSUE and set busy=1.
  - ack is never asserted twice for one req. The requester drops req the cycle after ack; if req is still high on the cycle after the ack, treat it as a new request.
- ISSUE:
  - mem_rd_req=1 while remaining_issue>0 and outstanding<MAX_OUTSTANDING. mem_rd_req and mem_rd_addr are registered outputs.
  - On mem_rd_req & mem_rd_gnt: addr increments by 1 (wraps modulo 2^ADDR_W), remaining_issue decrements, outstanding increments.
  - mem_rd_addr is held stable while req=1 and gnt=0.
  - When the last request is granted, go to DRAIN.
- Return path, active in ISSUE and DRAIN:
  - Each mem_rd_dout_en decrements outstanding and remaining_ret.
  - The beat is registered: dout_en/dout appear exactly 1 cycle after mem_rd_dout_en.
  - dout_eop=1 with the beat for which remaining_ret was 1.
  - If a grant and a return occur in the same cycle, outstanding is unchanged (net 0).
  - A return that brings outstanding to MAX_OUTSTANDING-1 allows mem_rd_req in the next cycle.
- DRAIN: on the eop beat, busy drops at the next edge and the state returns to IDLE. A new ack is possible one cycle after eop.
- No backpressure on the dout side. The requester always accepts beats.
- The number of beats per transfer always equals length.

Decomposition:
- Package dma_pkg holds ADDR_W, DATA_W, and the state enum typedef {IDLE, ISSUE, DRAIN}.
- One natural sub-module, dma_outstanding_ctr: a saturating up/down counter with simultaneous inc/dec and a full flag for MAX_OUTSTANDING.

Test Plan:
- Single beat:
  - Stimulus: req with addr=8, length=1; memory returns 3 cycles after gnt.
  - Response: one ack pulse, mem_rd_addr=8, one dout_en with eop=1 arriving 1 cycle after mem_rd_dout_en, busy 1→0.
- Four beats:
  - Stimulus: addr=0x7FFFFFE, length=4, gnt always 1.
  - Response: addresses 0x7FFFFFE, 0x7FFFFFF, 0, 1; 4 beats with data in order; eop only on the 4th.
- Zero length:
  - Stimulus: length=0.
  - Response: ack pulse, no mem_rd_req, no dout_en, busy stays 0.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=8, length=20, memory withholds returns.
  - Response: exactly 8 grants, then mem_rd_req=0 until the first return, then issue resumes. Total 20 beats.
- Grant stall:
  - Stimulus: gnt=0 for 5 cycles during the 2nd request.
  - Response: mem_rd_addr held stable; no duplicate or skipped address.
- Reset mid-transfer:
  - Stimulus: rst after 3 of 10 beats, stray returns afterwards.
  - Response: all outputs 0 the cycle after reset, no eop, stray returns dropped, next request served normally.
